sm_issue_queue: RTL and testbench

// Operand front end for the sequential multiplier (SM). Accepts operand pairs on a valid/ready stream
// and buffers them in a DEPTH-entry FIFO. Launches one SM operation at a time (start pulse plus held

---
 rtl/sm_issue_queue.sv | 110 +++++++++++
 tb/tb_sm_issue_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_issue_queue.sv
// Operand FIFO + launcher for the sequential multiplier; push-to-result latency is 3 cycles plus SM busy time.
// Backpressure: in_ready drops at FIFO full; a blocked result register holds the finished op in WAIT_DONE.
module sm_issue_queue #(
    parameter int WIDTH_M = 16,
    parameter int WIDTH_P = 32,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_M-1:0]     in_multiplicand,
    input  logic [WIDTH_M-1:0]     in_multiplier,
    output logic                   sm_start,
    output logic [WIDTH_M-1:0]     sm_multiplicand,
    output logic [WIDTH_M-1:0]     sm_multiplier,
    input  logic [WIDTH_P-1:0]     sm_product,
    input  logic                   sm_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_P-1:0]     out_product,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state, state_nxt;
    logic [WIDTH_M-1:0]  mem_a [DEPTH];
    logic [WIDTH_M-1:0]  mem_b [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                push, pop, capture;

    // in_ready is forced low during reset so nothing is accepted into a FIFO being cleared.
    assign in_ready = reset && (count != CNT_FULL);
    assign push     = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        sm_start  = 1'b0;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && sm_ready) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                sm_start  = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!sm_ready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // SM holds its product while idle, so a blocked result just waits here.
                if (sm_ready && (!out_valid || out_ready)) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_multiplicand;
            mem_b[wr_ptr] <= in_multiplier;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            sm_multiplicand <= '0;
            sm_multiplier   <= '0;
            out_valid       <= 1'b0;
            out_product     <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_ONE;
                sm_multiplicand <= mem_a[rd_ptr];
                sm_multiplier   <= mem_b[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A capture in the same cycle as a consume keeps out_valid high.
            if (capture) begin
                out_valid   <= 1'b1;
                out_product <= sm_product;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sm_issue_queue.sv
// Bench for sm_issue_queue: behavioural SM with variable latency plus a queue-based reference model.
module tb_sm_issue_queue;
    localparam int WM = 16;
    localparam int WP = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WM-1:0] in_multiplicand = '0;
    logic [WM-1:0] in_multiplier = '0;
    logic          sm_start;
    logic [WM-1:0] sm_multiplicand;
    logic [WM-1:0] sm_multiplier;
    logic [WP-1:0] sm_product = '0;
    logic          sm_ready = 1'b1;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WP-1:0] out_product;
    logic [2:0]    count;

    sm_issue_queue #(.WIDTH_M(WM), .WIDTH_P(WP), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier),
        .sm_start(sm_start), .sm_multiplicand(sm_multiplicand), .sm_multiplier(sm_multiplier),
        .sm_product(sm_product), .sm_ready(sm_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_product(out_product), .count(count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural sequential multiplier: busy for sm_lat cycles after start, holds product while idle.
    int            sm_lat = 3;
    int            sm_busy = 0;
    logic [WM-1:0] sm_a = '0, sm_b = '0;
    always @(posedge clk) begin
        if (sm_start) begin
            sm_busy  <= sm_lat;
            sm_ready <= 1'b0;
            sm_a     <= sm_multiplicand;
            sm_b     <= sm_multiplier;
        end else if (sm_busy > 1) begin
            sm_busy <= sm_busy - 1;
        end else if (sm_busy == 1) begin
            sm_busy    <= 0;
            sm_ready   <= 1'b1;
            sm_product <= WP'(sm_a) * WP'(sm_b);
        end
    end

    // Reference model: accepted pairs queue up for launch and for in-order results.
    logic [2*WM-1:0] launch_q[$];
    logic [WP-1:0]   exp_q[$];
    int              pushes = 0, starts = 0, outs_total = 0, starts_total = 0;
    logic            prev_hold = 1'b0;
    logic [WP-1:0]   prev_prod = '0;
    logic [WM-1:0]   prev_a = '0, prev_b = '0;
    logic [2*WM-1:0] op;

    always @(negedge clk) begin
        if (!reset) begin
            launch_q.delete();
            exp_q.delete();
            pushes = 0;
            starts = 0;
            prev_hold = 1'b0;
            prev_a = '0;
            prev_b = '0;
        end else begin
            if (sm_start) begin
                starts++;
                starts_total++;
                if (launch_q.size() == 0) chk("launch_unexpected", 1, 0);
                else begin
                    op = launch_q.pop_front();
                    chk("launch_multiplicand", sm_multiplicand, op[2*WM-1:WM]);
                    chk("launch_multiplier", sm_multiplier, op[WM-1:0]);
                end
                prev_a = sm_multiplicand;
                prev_b = sm_multiplier;
            end else begin
                chk("sm_multiplicand_held", sm_multiplicand, prev_a);
                chk("sm_multiplier_held", sm_multiplier, prev_b);
            end
            chk("count", count, pushes - starts);
            chk("in_ready", in_ready, (pushes - starts) < DEPTH);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_product", out_product, prev_prod);
            end
            prev_hold = out_valid && !out_ready;
            prev_prod = out_product;
            if (in_valid && in_ready) begin
                pushes++;
                launch_q.push_back({in_multiplicand, in_multiplier});
                exp_q.push_back(WP'(in_multiplicand) * WP'(in_multiplier));
            end
            if (out_valid && out_ready) begin
                outs_total++;
                if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
                else chk("out_product", out_product, exp_q.pop_front());
            end
        end
    end

    task automatic push(input logic [WM-1:0] a, input logic [WM-1:0] b);
        logic got = 1'b0;
        in_valid = 1'b1;
        in_multiplicand = a;
        in_multiplier = b;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!got) chk("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
        idle(3);
    endtask

    int  base_outs, base_starts;
    logic rnd_done = 1'b0;

    initial begin
        // Reset held with in_valid asserted
        in_valid = 1'b1;
        in_multiplicand = 16'd9;
        in_multiplier = 16'd9;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sm_start", sm_start, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sm_multiplicand", sm_multiplicand, 0);
        chk("rst_out_product", out_product, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Single op
        out_ready = 1'b1;
        base_outs = outs_total;
        base_starts = starts_total;
        push(16'd3, 16'd5);
        drain();
        chk("single_starts", starts_total - base_starts, 1);
        chk("single_outs", outs_total - base_outs, 1);

        // Ordering with a slow SM
        sm_lat = 8;
        base_outs = outs_total;
        push(16'hFFFF, 16'hFFFF);
        push(16'd2, 16'd7);
        push(16'd0, 16'd9);
        push(16'd1, 16'd1);
        push(16'd4, 16'd4);
        drain();
        chk("order_outs", outs_total - base_outs, 5);

        // Backpressure
        sm_lat = 4;
        out_ready = 1'b0;
        push(16'd6, 16'd7);
        push(16'd8, 16'd9);
        idle(30);
        chk("bp_valid", out_valid, 1);
        chk("bp_product", out_product, 32'd42);
        chk("bp_count", count, 0);
        out_ready = 1'b1;
        drain();

        // Fill completely: result reg + SM + 4 in FIFO, 7th push stalls
        sm_lat = 3;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 7; i++) push(16'(i), 16'(i + 10));
            end
            begin
                idle(60);
                chk("full_count", count, DEPTH);
                chk("full_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Mid-operation reset abandons the in-flight result
        sm_lat = 20;
        push(16'd10, 16'd10);
        idle(6);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("abandoned_no_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        base_outs = outs_total;
        push(16'd2, 16'd3);
        drain();
        chk("post_reset_outs", outs_total - base_outs, 1);

        // Random traffic with random SM latency and consumer stalls
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    push(16'($urandom), 16'($urandom));
                    idle($urandom_range(0, 3));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    sm_lat = $urandom_range(1, 6);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
